mips_run_ctrl: RTL

Synthesizable run controller for the MIPS core(s). It holds reset, releases per-core resets in a staggered sequence, and gates the core clock-enable while the program runs. It counts run cycles and ends the run on an explicit halt request, a self-loop on the PC, or a cycle budget. It replaces fixed-time reset and stop sequencing with a parametrised, multi-core, halt-aware controller that sits between the top-level clock/reset and the core instances.

---
 rtl/mips_run_pkg.sv | 29 ++
 rtl/mips_halt_detect.sv | 64 ++++++
 rtl/mips_run_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mips_run_pkg;

  // Run controller states, in the order a run walks through them.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    RELEASE    = 3'd2,
    RUN        = 3'd3,
    DONE       = 3'd4
  } run_state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_RST_CYCLES  = 5;
  localparam int DEF_STAGGER     = 2;
  localparam int DEF_MAX_CYCLES  = 3000;
  localparam int DEF_HALT_STABLE = 4;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_AUTO_START  = 1;

  // Bits needed for a counter that must reach max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mips_halt_detect.sv
// Halt detector: flags a halt request or a pc that has stayed put for
// HALT_STABLE consecutive RUN samples. Latency: combinational on the
// current sample (history is registered). Backpressure: none.
// Ports: clear (new run), run (state is RUN), pc, halt_req in;
//        halt_by_req (request wins), halt_hit (pc self-loop, no request) out.
module mips_halt_detect
  import mips_run_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int HALT_STABLE = DEF_HALT_STABLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            run,
  input  logic [PC_W-1:0] pc,
  input  logic            halt_req,
  output logic            halt_hit,
  output logic            halt_by_req
);

  localparam int              ST_W   = cnt_width(HALT_STABLE - 1);
  localparam logic [ST_W-1:0] ST_TOP = ST_W'(HALT_STABLE - 1);

  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic            have_prev_q, have_prev_d;
  logic [ST_W-1:0] stable_q, stable_d;

  always_comb begin
    prev_pc_d   = prev_pc_q;
    have_prev_d = have_prev_q;
    stable_d    = stable_q;
    if (clear) begin
      have_prev_d = 1'b0;
      stable_d    = '0;
    end else if (run) begin
      prev_pc_d   = pc;
      have_prev_d = 1'b1;
      // The first RUN sample has nothing to compare against.
      if (have_prev_q && (pc == prev_pc_q)) begin
        stable_d = (stable_q == ST_TOP) ? ST_TOP : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
    end
  end

  // An explicit request outranks the self-loop detection.
  assign halt_by_req = run && halt_req;
  assign halt_hit    = run && !halt_req && (stable_d == ST_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_q   <= '0;
      have_prev_q <= 1'b0;
      stable_q    <= '0;
    end else begin
      prev_pc_q   <= prev_pc_d;
      have_prev_q <= have_prev_d;
      stable_q    <= stable_d;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: holds core resets, releases them staggered, enables the
// cores while running and stops on halt, pc self-loop or cycle budget.
// Latency: all outputs registered, one cycle after the state decision.
// Backpressure: none; start outside IDLE/DONE is ignored.
// Ports: start, halt_req, pc in; core_rst[NUM_CH], core_en, running, done,
//        timeout, cycles, halt_pc out.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_STABLE = DEF_HALT_STABLE,
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int AUTO_START  = DEF_AUTO_START
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic [PC_W-1:0]   pc,
  output logic [NUM_CH-1:0] core_rst,
  output logic              core_en,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycles,
  output logic [PC_W-1:0]   halt_pc
);

  // RELEASE phase index at which the last channel comes out of reset.
  localparam int LAST_REL = STAGGER * (NUM_CH - 1);
  localparam int PH_MAX   = (RST_CYCLES - 1 > LAST_REL) ? RST_CYCLES - 1 : LAST_REL;
  localparam int PH_W     = cnt_width(PH_MAX);
  localparam logic [CNT_W:0] BUDGET = (CNT_W + 1)'(MAX_CYCLES);

  run_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [NUM_CH-1:0] core_rst_q, core_rst_d;
  logic              core_en_q, core_en_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;

  logic clear_run, halt_hit, halt_by_req, budget_hit;

  mips_halt_detect #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt_detect (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_run),
    .run         (state_q == RUN),
    .pc          (pc),
    .halt_req    (halt_req),
    .halt_hit    (halt_hit),
    .halt_by_req (halt_by_req)
  );

  // Extra top bit keeps the +1 from wrapping when cycles is saturated.
  assign budget_hit = (({1'b0, cycles_q} + 1'b1) == BUDGET);

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    halt_pc_d = halt_pc_q;
    clear_run = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start || ((state_q == IDLE) && (AUTO_START != 0))) begin
          state_d   = RESET_HOLD;
          ph_d      = '0;
          cycles_d  = '0;
          timeout_d = 1'b0;
          clear_run = 1'b1;
        end
      end
      RESET_HOLD: begin
        if (ph_q == PH_W'(RST_CYCLES - 1)) begin
          state_d = RELEASE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      RELEASE: begin
        if (ph_q == PH_W'(LAST_REL)) begin
          state_d = RUN;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      RUN: begin
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
        if (halt_by_req || halt_hit || budget_hit) begin
          state_d   = DONE;
          halt_pc_d = pc;
          timeout_d = !(halt_by_req || halt_hit);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they line up with it once registered.
    core_rst_d = '0;
    case (state_d)
      IDLE, RESET_HOLD: core_rst_d = '1;
      RELEASE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          core_rst_d[i] = (int'(ph_d) < STAGGER * i);
        end
      end
      default: core_rst_d = '0;
    endcase
    core_en_d = (state_d == RUN);
    running_d = (state_d == RESET_HOLD) || (state_d == RELEASE) || (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      core_rst_q <= '1;
      core_en_q  <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
      halt_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
      running_q  <= running_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
      halt_pc_q  <= halt_pc_d;
    end
  end

  assign core_rst = core_rst_q;
  assign core_en  = core_en_q;
  assign running  = running_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign cycles   = cycles_q;
  assign halt_pc  = halt_pc_q;

endmodule
